// File: rtl/life_pkg.sv
// Shared Game-of-Life geometry and the row store sequencer state encoding.
package life_pkg;

    localparam int COLUMNS       = 640;
    localparam int ROWS          = 480;
    localparam int ROW_WORDS     = 40;
    localparam int WORD_BITS     = 16;
    localparam int H_BLANK_START = 640;
    localparam int LINE_COLS     = 800;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        DRAIN  = 3'd3,
        COMMIT = 3'd4
    } seqState_t;

endpackage

// File: rtl/row_store_sequencer_addr_calc.sv
// Wraps a scan line plus offset into 0..479 and forms the word address rowIdx*40 + wordIdx.
module row_addr_calc
    import life_pkg::*;
(
    input  logic [8:0]  baseRow,
    input  logic [8:0]  offset,
    input  logic [5:0]  wordIdx,
    output logic [14:0] addr
);

    logic [9:0] rowSum;
    logic [9:0] rowWrapped;
    logic [8:0] rowIdx;

    // Both operands are below 480, so one conditional subtract is enough.
    always_comb begin
        rowSum     = {1'b0, baseRow} + {1'b0, offset};
        rowWrapped = rowSum;
        if (rowSum >= 10'(ROWS)) begin
            rowWrapped = rowSum - 10'(ROWS);
        end
        rowIdx = rowWrapped[8:0];
        addr   = ({6'd0, rowIdx} << 5) + ({6'd0, rowIdx} << 3) + {9'd0, wordIdx};
    end

endmodule

// File: rtl/row_store_sequencer.sv
// Per-scan-line write-back and fetch of one Game-of-Life row during horizontal blanking.
module row_store_sequencer
    import life_pkg::*;
#(
    parameter int WRITE_OFFSET = 479,
    parameter int READ_OFFSET  = 2,
    parameter int PRIME_ROW0   = 490,
    parameter int PRIME_ROW1   = 491,
    parameter int DEADLINE_COL = 790
) (
    input  logic         clkDiv,
    input  logic         rst,
    input  logic [8:0]   row,
    input  logic [9:0]   column,
    input  logic [639:0] writeRow,
    output logic [639:0] readRow,
    output logic         reading,
    output logic [14:0]  memAddr,
    output logic [15:0]  memWData,
    output logic         memWe,
    output logic         memRe,
    input  logic [15:0]  memRData,
    output logic         busy,
    output logic         overrun
);

    localparam logic [9:0] hBlankCol   = 10'(H_BLANK_START);
    localparam logic [9:0] deadlineCol = 10'(DEADLINE_COL);
    localparam logic [8:0] wrOff       = 9'(WRITE_OFFSET);
    localparam logic [8:0] rdOff       = 9'(READ_OFFSET);
    localparam logic [8:0] prime0      = 9'(PRIME_ROW0);
    localparam logic [8:0] prime1      = 9'(PRIME_ROW1);
    localparam logic [8:0] rowLimit    = 9'(ROWS);
    localparam logic [5:0] lastWord    = 6'(ROW_WORDS - 1);

    seqState_t  state;
    logic [5:0] wordIdx;
    logic [8:0] baseRow;
    logic       primeRead;
    logic [8:0] offsetSel;
    logic [14:0] calcAddr;
    logic       startEvt;

    logic [639:0] writeBuf;
    logic [15:0]  staging [ROW_WORDS];
    logic [(ROW_WORDS-1)*WORD_BITS-1:0] stagingLow;

    assign startEvt = (column == hBlankCol);

    always_comb begin
        offsetSel = '0;
        if (state == WRITE) begin
            offsetSel = wrOff;
        end else if (!primeRead) begin
            offsetSel = rdOff;
        end
    end

    row_addr_calc uAddrCalc (
        .baseRow (baseRow),
        .offset  (offsetSel),
        .wordIdx (wordIdx),
        .addr    (calcAddr)
    );

    always_comb begin
        memWe    = (state == WRITE);
        memRe    = (state == READ);
        busy     = (state != IDLE);
        memAddr  = (memWe || memRe) ? calcAddr : '0;
        memWData = memWe ? writeBuf[{wordIdx, 4'b0000} +: 16] : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROW_WORDS - 1; gi++) begin : gStage
            assign stagingLow[gi*WORD_BITS +: WORD_BITS] = staging[gi];
        end
    endgenerate

    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wordIdx   <= '0;
            baseRow   <= '0;
            primeRead <= 1'b0;
            reading   <= 1'b0;
            readRow   <= '0;
            overrun   <= 1'b0;
        end else begin
            if ((column == deadlineCol || startEvt) && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (startEvt) begin
                        wordIdx <= '0;
                        if (row < rowLimit) begin
                            baseRow   <= row;
                            primeRead <= 1'b0;
                            reading   <= 1'b0;
                            state     <= WRITE;
                        end else if (row == prime0 || row == prime1) begin
                            baseRow   <= (row == prime0) ? 9'd0 : 9'd1;
                            primeRead <= 1'b1;
                            reading   <= 1'b0;
                            state     <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wordIdx == lastWord) begin
                        wordIdx <= '0;
                        state   <= READ;
                    end else begin
                        wordIdx <= wordIdx + 6'd1;
                    end
                end
                READ: begin
                    if (wordIdx == lastWord) begin
                        wordIdx <= '0;
                        state   <= DRAIN;
                    end else begin
                        wordIdx <= wordIdx + 6'd1;
                    end
                end
                DRAIN: begin
                    // Word 39 is forwarded straight from memRData so the new row
                    // and the reading edge are both visible in the COMMIT cycle.
                    readRow <= {memRData, stagingLow};
                    reading <= 1'b1;
                    state   <= COMMIT;
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkDiv) begin
        if (state == IDLE && startEvt && row < rowLimit) begin
            writeBuf <= writeRow;
        end
        if (state == READ && wordIdx != 6'd0) begin
            staging[wordIdx - 6'd1] <= memRData;
        end
        if (state == DRAIN) begin
            staging[lastWord] <= memRData;
        end
    end

endmodule

// File: tb/tb_row_store_sequencer.sv
// Directed bench: full scan lines with a word=address memory model and hand-computed addresses.
module tb_row_store_sequencer;

    logic         clkDiv;
    logic         rst;
    logic [8:0]   row;
    logic [9:0]   column;
    logic [639:0] writeRow;
    logic [639:0] readRow;
    logic         reading;
    logic [14:0]  memAddr;
    logic [15:0]  memWData;
    logic         memWe;
    logic         memRe;
    logic [15:0]  memRData;
    logic         busy;
    logic         overrun;

    int nChecks = 0;
    int nFails  = 0;

    int nWr, nRd, wrBad, rdBad, bothHigh, riseCol, rowChg;

    row_store_sequencer dut (
        .clkDiv   (clkDiv),
        .rst      (rst),
        .row      (row),
        .column   (column),
        .writeRow (writeRow),
        .readRow  (readRow),
        .reading  (reading),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memWe    (memWe),
        .memRe    (memRe),
        .memRData (memRData),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clkDiv = 1'b0;
    always #5 clkDiv = ~clkDiv;

    // Memory model: each word reads back as its own address.
    initial memRData = '0;
    always @(posedge clkDiv) begin
        if (memRe) memRData <= {1'b0, memAddr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int badWords(input int base);
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (readRow[16*i +: 16] != 16'(base + i)) bad++;
        end
        return bad;
    endfunction

    task automatic runLine(input int r, input logic [639:0] wr, input int wrBase, input int rdBase,
                           input int expRise, input int abortAt, input bit hold);
        logic [639:0] refRow;
        bit prevReading;
        int oc;
        int reps;
        nWr = 0; nRd = 0; wrBad = 0; rdBad = 0; bothHigh = 0; riseCol = -1; rowChg = 0;
        refRow = readRow;
        prevReading = reading;
        row = r[8:0];
        writeRow = wr;
        for (int c = 0; c < 800; c++) begin
            reps = (hold && c == 640) ? 2 : 1;
            for (int k = 0; k < reps; k++) begin
                column = c[9:0];
                @(posedge clkDiv);
                #1;
                oc = c + 1;
                if (memWe && memRe) bothHigh++;
                if (memWe) begin
                    if (nWr >= 40) wrBad++;
                    else if (memAddr != 15'(wrBase + nWr) || memWData != wr[16*nWr +: 16]) wrBad++;
                    nWr++;
                end
                if (memRe) begin
                    if (nRd >= 40 || memAddr != 15'(rdBase + nRd)) rdBad++;
                    nRd++;
                end
                if (reading && !prevReading && riseCol < 0) riseCol = oc;
                prevReading = reading;
                if (oc < expRise && readRow != refRow) rowChg++;
                if (abortAt >= 0 && nWr == abortAt + 1) begin
                    $display("line row=%0d aborted at col=%0d writes=%0d", r, oc, nWr);
                    return;
                end
            end
        end
        $display("line row=%0d writes=%0d reads=%0d rise=%0d overrun=%0d", r, nWr, nRd, riseCol, overrun);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clkDiv);
        #1;
        rst = 1'b0;
    endtask

    logic [639:0] patA;
    logic [639:0] patB;

    initial begin
        rst = 1'b1;
        row = '0;
        column = '0;
        writeRow = '0;
        for (int i = 0; i < 40; i++) begin
            patA[16*i +: 16] = 16'hAAAA;
            patB[16*i +: 16] = 16'h1000 + 16'(i);
        end
        repeat (3) @(posedge clkDiv);
        #1;
        check("rst_readRow", 32'(readRow != '0), 0);
        check("rst_reading", 32'(reading), 0);
        check("rst_memWe", 32'(memWe), 0);
        check("rst_memRe", 32'(memRe), 0);
        check("rst_memAddr", 32'(memAddr), 0);
        check("rst_memWData", 32'(memWData), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;

        // row 5: write row 4, read row 7
        runLine(5, patA, 160, 280, 722, -1, 1'b0);
        check("r5_nWr", 32'(nWr), 40);
        check("r5_wrBad", 32'(wrBad), 0);
        check("r5_nRd", 32'(nRd), 40);
        check("r5_rdBad", 32'(rdBad), 0);
        check("r5_both", 32'(bothHigh), 0);
        check("r5_rise", 32'(riseCol), 722);
        check("r5_stable", 32'(rowChg), 0);
        check("r5_word0", 32'(readRow[15:0]), 280);
        check("r5_word39", 32'(readRow[639:624]), 319);
        check("r5_words", 32'(badWords(280)), 0);
        check("r5_overrun", 32'(overrun), 0);

        runLine(479, patB, 19120, 40, 722, -1, 1'b0);
        check("r479_nWr", 32'(nWr), 40);
        check("r479_wrBad", 32'(wrBad), 0);
        check("r479_rdBad", 32'(rdBad), 0);
        check("r479_stable", 32'(rowChg), 0);
        check("r479_words", 32'(badWords(40)), 0);

        runLine(478, patB, 19080, 0, 722, -1, 1'b0);
        check("r478_wrBad", 32'(wrBad), 0);
        check("r478_nRd", 32'(nRd), 40);
        check("r478_rdBad", 32'(rdBad), 0);
        check("r478_words", 32'(badWords(0)), 0);

        runLine(490, patA, 0, 0, 682, -1, 1'b0);
        check("p0_nWr", 32'(nWr), 0);
        check("p0_nRd", 32'(nRd), 40);
        check("p0_rdBad", 32'(rdBad), 0);
        check("p0_rise", 32'(riseCol), 682);
        check("p0_stable", 32'(rowChg), 0);
        check("p0_word5", 32'(readRow[95:80]), 5);

        runLine(491, patA, 0, 40, 682, -1, 1'b0);
        check("p1_nWr", 32'(nWr), 0);
        check("p1_rdBad", 32'(rdBad), 0);
        check("p1_rise", 32'(riseCol), 682);
        check("p1_words", 32'(badWords(40)), 0);

        // a vertical-blank line that is not a prime line does nothing
        runLine(495, patA, 0, 0, 800, -1, 1'b0);
        check("vb_nWr", 32'(nWr), 0);
        check("vb_nRd", 32'(nRd), 0);
        check("vb_reading", 32'(reading), 1);
        check("vb_stable", 32'(rowChg), 0);

        // reset in the middle of the write burst
        runLine(10, patB, 360, 480, 722, 17, 1'b0);
        check("ab_addr", 32'(memAddr), 377);
        rst = 1'b1;
        @(posedge clkDiv);
        #1;
        check("ab_memWe", 32'(memWe), 0);
        check("ab_memAddr", 32'(memAddr), 0);
        check("ab_reading", 32'(reading), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_readRow", 32'(readRow != '0), 0);
        rst = 1'b0;

        // start event repeated while busy
        runLine(7, patB, 240, 360, 721, -1, 1'b1);
        check("ov_nWr", 32'(nWr), 40);
        check("ov_wrBad", 32'(wrBad), 0);
        check("ov_rdBad", 32'(rdBad), 0);
        check("ov_rise", 32'(riseCol), 721);
        check("ov_words", 32'(badWords(360)), 0);
        check("ov_set", 32'(overrun), 1);
        runLine(8, patA, 280, 400, 722, -1, 1'b0);
        check("ov_sticky", 32'(overrun), 1);
        check("ov_next_wrBad", 32'(wrBad), 0);
        pulseReset();
        check("ov_clear", 32'(overrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
